// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use stalls, branch
// flushes, and a pipeline freeze with watchdog while data memory is busy.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_en,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, WAIT_MEM} state_e;

  state_e           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic             mem_error_q, mem_error_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use, timeout, freeze;

  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
    timeout  = (state_q == WAIT_MEM) && !mem_ready && (timer_q == 8'(MEM_TIMEOUT));
    // In WAIT_MEM the exit cycle (ready or timeout) falls back to RUN rules
    // with the memory request ignored, so the freeze lifts in that same cycle.
    if (state_q == RUN)
      freeze = mem_req && !mem_ready;
    else
      freeze = !mem_ready && !timeout;
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mem_error_d = mem_error_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = WAIT_MEM;
          timer_d = 8'd1;
        end
      end
      WAIT_MEM: begin
        if (mem_ready) begin
          state_d = RUN;
          timer_d = 8'd0;
        end else if (timeout) begin
          state_d     = RUN;
          timer_d     = 8'd0;
          mem_error_d = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        state_d = RUN;
        timer_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_en    = 1'b1;
    if (!reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pipe_en    = 1'b0;
    end else if (freeze) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      timer_q     <= 8'd0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mem_error_q <= mem_error_d;
      if (!pc_en && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ifid_flush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign mem_error = mem_error_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall sequencer for the 5-stage pipeline CPU. It drives the PC, IF/ID, ID/EX and EX/MEM register enables and flushes, and decides when to stall, flush or freeze. It resolves load-use hazards and taken branches and jumps. It also freezes the whole pipeline while a multi-cycle data-memory access is outstanding, with a watchdog timeout and saturating performance counters. It sits beside the pipeline registers and consumes decoded control from the ID and EX stages.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum cycles spent in WAIT_MEM before timeout (legal range 2..255).
- CNT_W, 16: width of the performance counters.

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  EX instruction is a load (whatToReg selects memory).
- ex_rd  in  5  destination register of the EX instruction.
- ex_branch_taken  in  1  branch or jump resolved taken in EX (PCSel non-sequential).
- mem_req  in  1  MEM-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP (instruction 0); has priority over ifid_en.
- idex_flush  out  1  ID/EX loads a bubble (regWrite=0, memWrite=0).
- pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB.
- mem_error  out  1  sticky flag; set on memory timeout.
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating.
- flush_cnt  out  CNT_W  cycles with ifid_flush=1, saturating.

## Operation
- FSM states: RUN and WAIT_MEM. State resets to RUN.
- load_use = ex_mem_read & (ex_rd != 0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)). Register 0 never causes a hazard.
- Decisions in RUN are made in priority order; the first match wins:
  1. mem_req & !mem_ready → freeze: pc_en=0, ifid_en=0, pipe_en=0, no flushes; next state WAIT_MEM; timer loads 1.
  2. ex_branch_taken → pc_en=1, ifid_flush=1, idex_flush=1, pipe_en=1.
  3. load_use → pc_en=0, ifid_en=0, idex_flush=1, pipe_en=1 (one bubble inserted).
  4. Otherwise all enables are 1 and flushes are 0.
- WAIT_MEM:
  - Freeze outputs every cycle.
  - Timer increments each cycle.
  - mem_ready=1 → outputs revert to RUN rules this cycle, evaluated with the mem_req term ignored; next state RUN.
  - Timer reaches MEM_TIMEOUT without mem_ready → set mem_error, next state RUN. That exit cycle also evaluates RUN rules with mem_req ignored, so the access is abandoned.
- A taken branch held during WAIT_MEM is frozen in EX and is acted on at the exit cycle.
- mem_error is cleared only by reset.
- Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- All outputs are combinational from the current state and inputs, valid in the same cycle. Registers update on the rising edge of CLK.
- While reset=0: state=RUN, timer=0, mem_error=0, both counters 0. Outputs are forced to pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, pipe_en=0.
- First rising edge after reset deasserts: normal RUN evaluation applies.
- Load-use costs exactly 1 stall cycle. In the next cycle ex_mem_read is 0 (a bubble), so there is no repeat stall.
- Branch flush costs 2 instruction slots (IF/ID and ID/EX) in 1 cycle.
- Memory access with ready delay d (d ≥ 1): d frozen cycles, then the exit cycle.
- Timeout: mem_error is visible from the cycle after the MEM_TIMEOUT-th cycle in WAIT_MEM.
- Reset asserted in WAIT_MEM returns the FSM to RUN immediately (asynchronous); the pending access is dropped.
- stall_cnt and flush_cnt increment on the edge that ends a cycle with pc_en=0 or ifid_flush=1 respectively. Reset cycles are not counted.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_use_rs=1 for one cycle. Required: pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cnt goes 0→1. Repeat with ex_rd=0: no stall.
- Branch: ex_branch_taken=1 with load_use also true. Required: pc_en=1, ifid_flush=1, idex_flush=1; flush_cnt=1; stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready held 0 for 3 cycles then 1. Required: 3 freeze cycles (pc_en=pipe_en=0), resume on the 4th cycle; stall_cnt=3.
- Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ready=0 indefinitely. Required: FSM exits after 4 cycles in WAIT_MEM, then mem_error=1 and stays 1 until reset.
- Mid-operation reset: drop reset in the 2nd WAIT_MEM cycle. Required: outputs immediately at reset values, counters 0. On release with mem_req=0, pc_en=1.
- Saturation with CNT_W=4: hold load_use for 20 cycles. Required: stall_cnt stops at 15.
